irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 16, number of interrupt sources (2..64).
REQ-002 SHALL have parameter PRIO_W, default 3, width of per-source priority field.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port list, in order:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- irq_src  in  NUM_SRC  raw interrupt lines.
- gie  in  1  global interrupt enable from the trap unit.
- cfg_wr_en  in  1  configuration write strobe.
- cfg_wr_id  in  clog2(NUM_SRC)  source index.
- cfg_wr_data  in  PRIO_W+2  {prio, edge_mode, enable}.
- irq_valid  out  1  interrupt offered to the trap unit.
- irq_id  out  clog2(NUM_SRC)  offered source index.
- irq_ready  in  1  claim from the trap unit.
- cmpl_valid  in  1  handler completion strobe.
- cmpl_id  in  clog2(NUM_SRC)  completed source index.
- irq_pending  out  NUM_SRC  registered pending vector.
- irq_busy  out  1  a claimed source is in service.

Function
REQ-005 SHALL register irq_src into src_last every cycle.
REQ-006 Edge-mode source: SHALL set pending on the cycle src=1 and src_last=0.
REQ-007 Level-mode source: SHALL set pending while src=1.
REQ-008 Level-mode pending SHALL clear only when claimed.
REQ-009 A source is eligible iff pending, enable, gie, and it is not the in-service source.
REQ-010 FSM states SHALL be IDLE, OFFER and BUSY.
REQ-011 IDLE->OFFER: on the clock edge after any eligible source exists; latch the winner into irq_id.
REQ-012 OFFER: irq_valid=1; irq_id stays stable until irq_valid&irq_ready, even if eligibility changes or a better source arrives.
REQ-013 OFFER->BUSY on irq_valid&irq_ready: clear pending[irq_id], record the in-service id, assert irq_busy.
REQ-014 BUSY->IDLE on cmpl_valid with cmpl_id equal to the in-service id; a non-matching cmpl_id SHALL be ignored.
REQ-015 cmpl_valid outside BUSY SHALL be ignored.
REQ-016 Latency: with an eligible edge at clock edge E1, pending is visible after E1 and irq_valid=1 after E2.
REQ-017 Pending set and claim clear on the same cycle for the same source: set SHALL win, so the source stays pending.
REQ-018 A cfg write SHALL take effect the next cycle; it never clears pending.
REQ-019 cfg_wr_id >= NUM_SRC SHALL be ignored.

Reset
REQ-020 rst SHALL asynchronously clear pending, src_last, enable, edge_mode, prio, irq_valid, irq_id, irq_busy, and the in-service id, and force the FSM to IDLE.
REQ-021 rst asserted during OFFER or BUSY SHALL abandon the offer/service with no completion required.

Configuration
REQ-022 Macro IRQ_CTRL_PRIORITY_EN SHALL control priority arbitration.
REQ-023 Defined: winner = highest prio among eligible sources; ties go to the lowest index; prio 0 = never eligible.
REQ-024 Undefined: prio field stored as 0 and ignored; winner = lowest eligible index; prio 0 does not block.

Verification
REQ-025 Edge source 3 enabled, gie=1, pulse irq_src[3] one cycle -> irq_valid=1, irq_id=3 two edges later; after claim, pending[3]=0 and irq_busy=1.
REQ-026 Level source 5 held high, claimed, then cmpl_id=5 with source still high -> re-offered irq_id=5 within 2 cycles of completion.
REQ-027 With PRIORITY_EN, sources 1 (prio 2) and 7 (prio 6) pend together -> irq_id=7; without PRIORITY_EN -> irq_id=1.
REQ-028 During OFFER of id 4, source 2 with higher priority pends and irq_ready stays low 5 cycles -> irq_id stays 4 throughout.
REQ-029 BUSY on id 4, cmpl_id=6 -> remains BUSY; new edge on source 4 during BUSY -> pending[4]=1 but not offered until cmpl_id=4.
REQ-030 Assert rst mid-OFFER -> irq_valid=0, irq_busy=0, irq_pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with edge/level sources,
// a single offer/claim/complete handshake and per-source configuration.
// Optional feature macro: IRQ_CTRL_PRIORITY_EN. When defined, the
// per-source priority field drives arbitration. When undefined, the field
// is stored as zero and the lowest eligible index wins.
module irq_ctrl #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3,
  localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               gie,
  input  logic               cfg_wr_en,
  input  logic [ID_W-1:0]    cfg_wr_id,
  input  logic [PRIO_W+1:0]  cfg_wr_data,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ready,
  input  logic               cmpl_valid,
  input  logic [ID_W-1:0]    cmpl_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               irq_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_load_id;
  logic                w_load_svc;

  logic [NUM_SRC-1:0]  r_src_last;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_enable;
  logic [NUM_SRC-1:0]  r_edge;
  logic [PRIO_W-1:0]   r_prio [NUM_SRC];
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_svc_id;

  logic [NUM_SRC-1:0]  w_set;
  logic [NUM_SRC-1:0]  w_clr;
  logic [NUM_SRC-1:0]  w_prio_ok;
  logic [NUM_SRC-1:0]  w_eligible;
  logic                w_cfg_hit;
  logic                w_claim;
  logic                w_cmpl_hit;
  logic                w_any;
  logic [ID_W-1:0]     w_winner;

  // Indices beyond the last source are silently dropped.
  assign w_cfg_hit  = cfg_wr_en && (32'(cfg_wr_id) < 32'(NUM_SRC));
  assign w_claim    = (r_state == OFFER) && irq_ready;
  assign w_cmpl_hit = (r_state == BUSY) && cmpl_valid && (cmpl_id == r_svc_id);
  assign w_any      = |w_eligible;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi = gi + 1) begin : g_src
      // Edge sources latch a rising edge; level sources latch while high.
      assign w_set[gi] = r_edge[gi] ? (irq_src[gi] & ~r_src_last[gi]) : irq_src[gi];
      assign w_clr[gi] = w_claim && (r_id == ID_W'(gi));
`ifdef IRQ_CTRL_PRIORITY_EN
      // Priority zero masks the source entirely.
      assign w_prio_ok[gi] = |r_prio[gi];
`else
      assign w_prio_ok[gi] = 1'b1;
`endif
      // The source currently being serviced cannot be offered again.
      assign w_eligible[gi] = r_pending[gi] && r_enable[gi] && gie && w_prio_ok[gi] &&
                              !((r_state == BUSY) && (r_svc_id == ID_W'(gi)));
    end
  endgenerate

`ifndef IRQ_CTRL_PRIORITY_EN
  // Priority bits are accepted but carry no meaning in this build.
  logic [NUM_SRC-1:0] w_unused_prio;
  logic               w_unused_cfg;
  assign w_unused_cfg = ^cfg_wr_data[PRIO_W+1:2];
  generate
    for (gi = 0; gi < NUM_SRC; gi = gi + 1) begin : g_unused
      assign w_unused_prio[gi] = ^r_prio[gi];
    end
  endgenerate
`endif

  // Sample raw lines and update pending; a new set beats a same-cycle claim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_last <= '0;
      r_pending  <= '0;
    end else begin
      r_src_last <= irq_src;
      r_pending  <= w_set | (r_pending & ~w_clr);
    end
  end

  // Per-source configuration registers; writes never touch pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= '0;
      r_edge   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_prio[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_cfg_hit && (cfg_wr_id == ID_W'(i))) begin
          r_enable[i] <= cfg_wr_data[0];
          r_edge[i]   <= cfg_wr_data[1];
`ifdef IRQ_CTRL_PRIORITY_EN
          r_prio[i]   <= cfg_wr_data[PRIO_W+1:2];
`else
          r_prio[i]   <= '0;
`endif
        end
      end
    end
  end

`ifdef IRQ_CTRL_PRIORITY_EN
  logic [PRIO_W-1:0] w_best_prio;

  // Highest priority wins; strict compare keeps ties on the lowest index.
  always_comb begin
    w_winner    = '0;
    w_best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_eligible[i] && (r_prio[i] > w_best_prio)) begin
        w_best_prio = r_prio[i];
        w_winner    = ID_W'(i);
      end
    end
  end
`else
  logic w_found;

  // Lowest eligible index wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_eligible[i] && !w_found) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: offer a winner, hold it until claimed, then wait for completion.
  always_comb begin
    w_state_next = r_state;
    w_load_id    = 1'b0;
    w_load_svc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = OFFER;
          w_load_id    = 1'b1;
        end
      end
      OFFER: begin
        if (irq_ready) begin
          w_state_next = BUSY;
          w_load_svc   = 1'b1;
        end
      end
      BUSY: begin
        if (w_cmpl_hit) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Offered id is frozen for the whole offer; the claimed id becomes in-service.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id     <= '0;
      r_svc_id <= '0;
    end else begin
      if (w_load_id) begin
        r_id <= w_winner;
      end
      if (w_load_svc) begin
        r_svc_id <= r_id;
      end
    end
  end

  assign irq_valid   = (r_state == OFFER);
  assign irq_busy    = (r_state == BUSY);
  assign irq_id      = r_id;
  assign irq_pending = r_pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the interrupt controller.
// Honours IRQ_CTRL_PRIORITY_EN the same way the design does.
module tb_irq_ctrl;
  localparam int NUM = 12;
  localparam int PW  = 3;
  localparam int IDW = $clog2(NUM);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NUM-1:0]  irq_src = '0;
  logic            gie = 1'b0;
  logic            cfg_wr_en = 1'b0;
  logic [IDW-1:0]  cfg_wr_id = '0;
  logic [PW+1:0]   cfg_wr_data = '0;
  logic            irq_valid;
  logic [IDW-1:0]  irq_id;
  logic            irq_ready = 1'b0;
  logic            cmpl_valid = 1'b0;
  logic [IDW-1:0]  cmpl_id = '0;
  logic [NUM-1:0]  irq_pending;
  logic            irq_busy;

  irq_ctrl #(.NUM_SRC(NUM), .PRIO_W(PW)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .gie(gie),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_id(cfg_wr_id), .cfg_wr_data(cfg_wr_data),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
    .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id),
    .irq_pending(irq_pending), .irq_busy(irq_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit m_pend [NUM];
  bit m_last [NUM];
  bit m_en   [NUM];
  bit m_edge [NUM];
  int m_prio [NUM];
  bit m_offer;
  bit m_busy;
  int m_id;
  int m_svc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(int i);
    bit e;
    e = m_pend[i] && m_en[i] && gie && !(m_busy && (i == m_svc));
`ifdef IRQ_CTRL_PRIORITY_EN
    e = e && (m_prio[i] != 0);
`endif
    return e;
  endfunction

  function automatic logic [NUM-1:0] pend_vec();
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = 0; m_last[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prio[i] = 0;
    end
    m_offer = 0; m_busy = 0; m_id = 0; m_svc = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit claim, any, set;
    int win, best, id;
    bit np [NUM];
    claim = m_offer && irq_ready;
    any = 0; win = 0; best = 0;
    for (int i = 0; i < NUM; i++) begin
      if (elig(i)) begin
`ifdef IRQ_CTRL_PRIORITY_EN
        if (m_prio[i] > best) begin best = m_prio[i]; win = i; any = 1; end
`else
        if (!any) begin any = 1; win = i; end
`endif
      end
    end
    for (int i = 0; i < NUM; i++) begin
      set   = m_edge[i] ? (irq_src[i] && !m_last[i]) : irq_src[i];
      np[i] = set || (m_pend[i] && !(claim && (m_id == i)));
    end
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = np[i];
      m_last[i] = irq_src[i];
    end
    id = int'(cfg_wr_id);
    if (cfg_wr_en && id < NUM) begin
      m_en[id]   = cfg_wr_data[0];
      m_edge[id] = cfg_wr_data[1];
`ifdef IRQ_CTRL_PRIORITY_EN
      m_prio[id] = int'(cfg_wr_data[PW+1:2]);
`else
      m_prio[id] = 0;
`endif
    end
    if (m_offer) begin
      if (irq_ready) begin m_offer = 0; m_busy = 1; m_svc = m_id; end
    end else if (m_busy) begin
      if (cmpl_valid && (int'(cmpl_id) == m_svc)) m_busy = 0;
    end else if (any) begin
      m_offer = 1; m_id = win;
    end
  endtask

  task automatic check_outputs();
    check("valid", irq_valid, m_offer);
    check("busy", irq_busy, m_busy);
    check("id", irq_id, m_id);
    check("pending", irq_pending, pend_vec());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Called in the low clock phase; checks the asynchronous clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", irq_valid, 0);
    check("rst_busy", irq_busy, 0);
    check("rst_pending", irq_pending, 0);
    check("rst_id", irq_id, 0);
    model_reset();
    irq_src = '0; gie = 1'b0; cfg_wr_en = 1'b0; irq_ready = 1'b0; cmpl_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  task automatic cfg_write(input int id, input int p, input bit e, input bit n);
    cfg_wr_en   = 1'b1;
    cfg_wr_id   = IDW'(id);
    cfg_wr_data = {PW'(p), e, n};
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic pulse(input int s);
    irq_src[s] = 1'b1; tick(); irq_src[s] = 1'b0;
  endtask

  task automatic claim();
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
  endtask

  task automatic complete(input int id);
    cmpl_valid = 1'b1; cmpl_id = IDW'(id); tick(); cmpl_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Edge source 3: pending after E1, offered after E2, cleared on claim
    gie = 1'b1;
    cfg_write(3, 1, 1'b1, 1'b1);
    irq_src[3] = 1'b1; tick();
    check("e3_pend_E1", irq_pending[3], 1);
    check("e3_valid_E1", irq_valid, 0);
    irq_src[3] = 1'b0; tick();
    check("e3_valid_E2", irq_valid, 1);
    check("e3_id_E2", irq_id, 3);
    claim();
    check("e3_pend_claimed", irq_pending[3], 0);
    check("e3_busy", irq_busy, 1);
    complete(3);
    check("e3_done", irq_busy, 0);

    // Busy on 4: foreign completion ignored, re-edge held until own completion
    cfg_write(4, 2, 1'b1, 1'b1);
    pulse(4); tick();
    check("b4_offer_id", irq_id, 4);
    claim();
    complete(6);
    check("b4_still_busy", irq_busy, 1);
    pulse(4); tick();
    check("b4_repend", irq_pending[4], 1);
    check("b4_not_offered", irq_valid, 0);
    complete(4);
    check("b4_released", irq_busy, 0);
    tick();
    check("b4_reoffer_valid", irq_valid, 1);
    check("b4_reoffer_id", irq_id, 4);
    claim();
    complete(4);

    // Offer of 4 stays stable while a better source 2 arrives
    cfg_write(2, 5, 1'b1, 1'b1);
    pulse(4); tick();
    pulse(2);
    for (int k = 0; k < 4; k++) begin
      check("hold_id", irq_id, 4);
      tick();
    end
    check("hold_id_last", irq_id, 4);
    check("hold_pend2", irq_pending[2], 1);
    // Reset in the middle of the offer
    do_reset();

    // Level source 5 re-offered after completion while still high
    gie = 1'b1;
    cfg_write(5, 3, 1'b0, 1'b1);
    irq_src[5] = 1'b1;
    tick(); tick();
    check("l5_id", irq_id, 5);
    claim();
    check("l5_pend_kept", irq_pending[5], 1);
    check("l5_busy", irq_busy, 1);
    complete(5);
    tick();
    check("l5_reoffer", irq_valid, 1);
    check("l5_reoffer_id", irq_id, 5);
    irq_src[5] = 1'b0;
    claim();
    check("l5_pend_clear", irq_pending[5], 0);
    complete(5);

    // Arbitration between sources 1 (prio 2) and 7 (prio 6)
    cfg_write(1, 2, 1'b1, 1'b1);
    cfg_write(7, 6, 1'b1, 1'b1);
    irq_src[1] = 1'b1; irq_src[7] = 1'b1; tick();
    irq_src = '0; tick();
`ifdef IRQ_CTRL_PRIORITY_EN
    check("arb_id", irq_id, 7);
`else
    check("arb_id", irq_id, 1);
`endif

    // Randomized traffic
    do_reset();
    gie = 1'b1;
    for (int i = 0; i < NUM; i++)
      cfg_write(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)), ($urandom % 4) != 0);
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 400) == 0) begin
        do_reset();
      end
      for (int i = 0; i < NUM; i++) irq_src[i] = (($urandom % 6) == 0);
      gie         = (($urandom % 10) != 0);
      cfg_wr_en   = (($urandom % 20) == 0);
      cfg_wr_id   = IDW'($urandom_range(0, (1 << IDW) - 1));
      cfg_wr_data = (PW + 2)'($urandom);
      irq_ready   = (($urandom % 3) == 0);
      cmpl_valid  = (($urandom % 3) == 0);
      cmpl_id     = (($urandom % 4) == 0) ? IDW'($urandom) : IDW'(m_svc);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
